// File: rtl/sparse_pkg.sv
// Shared types and helpers for the N:M structured-sparsity decompressor.
// Fixed group geometry, mode encoding and mask popcount helpers.
package sparse_pkg;

  localparam int SP_M = 8;
  localparam int SP_K = SP_M / 2;
  localparam int SP_SLOT_IDX_W = $clog2(SP_K);

  typedef enum logic {
    SP_MODE_2_4 = 1'b0,
    SP_MODE_4_8 = 1'b1
  } sp_mode_e;

  typedef logic [SP_SLOT_IDX_W-1:0] slot_idx_t;

  function automatic logic [3:0] popcount4(input logic [3:0] v);
    return {3'b000, v[0]} + {3'b000, v[1]} + {3'b000, v[2]} + {3'b000, v[3]};
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    return popcount4(v[3:0]) + popcount4(v[7:4]);
  endfunction

endpackage

// File: rtl/sparse_group_expand.sv
// Combinational expansion of one compressed group. The index/keep/err half is
// evaluated before stage 1, the slot mux half after it, so the parent splits them.
module sparse_group_expand
  import sparse_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [SP_M-1:0]             mask_i,
  input  sp_mode_e                    mode_i,
  output slot_idx_t [SP_M-1:0]        idx_o,
  output logic [SP_M-1:0]             keep_o,
  output logic                        err_o,
  input  logic [SP_K*W-1:0]           slots_i,
  input  slot_idx_t [SP_M-1:0]        idx_i,
  input  logic [SP_M-1:0]             keep_i,
  output logic [SP_M*W-1:0]           vals_o
);

  genvar gi;

  for (gi = 0; gi < SP_M; gi++) begin : g_pos
    localparam int SUB_LO = (gi / 4) * 4;
    logic [3:0] cnt_all;
    logic [3:0] cnt_sub;
    slot_idx_t  idx_sub;

    always_comb begin
      cnt_all = '0;
      cnt_sub = '0;
      for (int j = 0; j < gi; j++) begin
        cnt_all = cnt_all + {3'b000, mask_i[j]};
      end
      for (int j = SUB_LO; j < gi; j++) begin
        cnt_sub = cnt_sub + {3'b000, mask_i[j]};
      end
    end

    // In 2:4 each nibble owns its own pair of slots starting at 2*subgroup.
    assign idx_sub    = slot_idx_t'((gi / 4) * 2) | slot_idx_t'(cnt_sub[0]);
    assign idx_o[gi]  = (mode_i == SP_MODE_4_8) ? cnt_all[SP_SLOT_IDX_W-1:0] : idx_sub;
    assign keep_o[gi] = mask_i[gi] &&
                        ((mode_i == SP_MODE_4_8) ? (cnt_all < 4'd4) : (cnt_sub < 4'd2));
  end

  assign err_o = (mode_i == SP_MODE_4_8) ? (popcount8(mask_i) > 4'd4)
                                         : ((popcount4(mask_i[3:0]) > 4'd2) ||
                                            (popcount4(mask_i[7:4]) > 4'd2));

  logic [W-1:0] slot_arr [SP_K];

  // Slot 0 sits in the most-significant W bits of the packed group.
  for (gi = 0; gi < SP_K; gi++) begin : g_slot
    assign slot_arr[gi] = slots_i[(SP_K-1-gi)*W +: W];
  end

  for (gi = 0; gi < SP_M; gi++) begin : g_mux
    assign vals_o[gi*W +: W] = keep_i[gi] ? slot_arr[idx_i[gi]] : '0;
  end

endmodule

// File: rtl/sparse_decompressor_nm.sv
// Two-stage N:M (2:4 / 4:8) sparse operand decompressor with valid/ready flow control.
// Optional SPARSE_DECOMP_STATS_EN adds saturating beat and error counters.
module sparse_decompressor_nm
  import sparse_pkg::*;
#(
  parameter int W     = 16,
  parameter int M     = 8,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [LANES*M/2*W-1:0] in_vals,
  input  logic [LANES*M-1:0]     in_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*M*W-1:0]   out_vals,
  output logic [LANES-1:0]       out_err,
  output logic                   err_sticky,
  input  logic                   err_clr
`ifdef SPARSE_DECOMP_STATS_EN
  ,
  output logic [31:0]            beat_cnt,
  output logic [31:0]            err_cnt
`endif
);

  localparam int K = M / 2;

  if (M != SP_M) begin : g_bad_m
    $error("sparse_decompressor_nm: M must be 8 in this generation");
  end

  slot_idx_t [LANES-1:0][M-1:0] lane_idx;
  logic [LANES-1:0][M-1:0]      lane_keep;
  logic [LANES-1:0]             lane_err;
  logic [LANES*M*W-1:0]         lane_dense;

  logic                         s1_valid_q, s1_valid_d;
  logic [LANES*K*W-1:0]         s1_vals_q, s1_vals_d;
  slot_idx_t [LANES-1:0][M-1:0] s1_idx_q, s1_idx_d;
  logic [LANES-1:0][M-1:0]      s1_keep_q, s1_keep_d;
  logic [LANES-1:0]             s1_err_q, s1_err_d;

  logic                         s2_valid_q, s2_valid_d;
  logic [LANES*M*W-1:0]         s2_vals_q, s2_vals_d;
  logic [LANES-1:0]             s2_err_q, s2_err_d;

  logic                         err_sticky_q, err_sticky_d;
  logic                         s1_adv, s2_adv, in_hs, out_hs;

  genvar gi;

  for (gi = 0; gi < LANES; gi++) begin : g_lane
    sparse_group_expand #(.W(W)) u_expand (
      .mask_i  (in_mask[gi*M +: M]),
      .mode_i  (sp_mode_e'(in_mode)),
      .idx_o   (lane_idx[gi]),
      .keep_o  (lane_keep[gi]),
      .err_o   (lane_err[gi]),
      .slots_i (s1_vals_q[gi*K*W +: K*W]),
      .idx_i   (s1_idx_q[gi]),
      .keep_i  (s1_keep_q[gi]),
      .vals_o  (lane_dense[gi*M*W +: M*W])
    );
  end

  always_comb begin
    s2_adv    = !s2_valid_q || out_ready;
    s1_adv    = !s1_valid_q || s2_adv;
    in_ready  = s1_adv && !rst;
    in_hs     = in_valid && in_ready;
    // Masking with rst guarantees no output handshake in a reset cycle.
    out_valid = s2_valid_q && !rst;
    out_hs    = out_valid && out_ready;

    s1_valid_d   = s1_valid_q;
    s1_vals_d    = s1_vals_q;
    s1_idx_d     = s1_idx_q;
    s1_keep_d    = s1_keep_q;
    s1_err_d     = s1_err_q;
    s2_valid_d   = s2_valid_q;
    s2_vals_d    = s2_vals_q;
    s2_err_d     = s2_err_q;
    err_sticky_d = err_sticky_q;

    if (s1_adv) begin
      s1_valid_d = in_hs;
      if (in_hs) begin
        s1_vals_d = in_vals;
        s1_idx_d  = lane_idx;
        s1_keep_d = lane_keep;
        s1_err_d  = lane_err;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_vals_d = lane_dense;
        s2_err_d  = s1_err_q;
      end
    end

    if (out_hs && (|s2_err_q)) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_vals_q    <= '0;
      s1_idx_q     <= '0;
      s1_keep_q    <= '0;
      s1_err_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_vals_q    <= '0;
      s2_err_q     <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_vals_q    <= s1_vals_d;
      s1_idx_q     <= s1_idx_d;
      s1_keep_q    <= s1_keep_d;
      s1_err_q     <= s1_err_d;
      s2_valid_q   <= s2_valid_d;
      s2_vals_q    <= s2_vals_d;
      s2_err_q     <= s2_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_vals   = s2_vals_q;
  assign out_err    = s2_err_q;
  assign err_sticky = err_sticky_q;

`ifdef SPARSE_DECOMP_STATS_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (out_hs && (beat_cnt_q != '1)) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
    end
    if (out_hs && (|s2_err_q) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_sparse_decompressor_nm.sv
// Scoreboard bench for sparse_decompressor_nm: directed beats with hand-computed
// dense images, checked by an independent output monitor.
module tb_sparse_decompressor_nm;

  localparam int W = 16;
  localparam int M = 8;
  localparam int LANES = 4;
  localparam int K = 4;
  localparam int NV = 11;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   in_mode = 1'b0;
  logic [LANES*K*W-1:0]   in_vals = '0;
  logic [LANES*M-1:0]     in_mask = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [LANES*M*W-1:0]   out_vals;
  logic [LANES-1:0]       out_err;
  logic                   err_sticky;
  logic                   err_clr = 1'b0;
`ifdef SPARSE_DECOMP_STATS_EN
  logic [31:0]            beat_cnt;
  logic [31:0]            err_cnt;
`endif

  sparse_decompressor_nm #(.W(W), .M(M), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_vals    (in_vals),
    .in_mask    (in_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vals   (out_vals),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
`ifdef SPARSE_DECOMP_STATS_EN
    ,
    .beat_cnt   (beat_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES*M*W-1:0] vals;
    logic [LANES-1:0]     err;
    logic [7:0]           id;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cyc[$];
  int   out_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cnt = 0;

  // Vector table: lane, mode (0=2:4,1=4:8), mask, slots {s0,s1,s2,s3}, dense {p7..p0}, err.
  logic [1:0]   v_lane  [NV] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3};
  logic         v_mode  [NV] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0]   v_mask  [NV] = '{8'b1010_0101, 8'b0011_0110, 8'b0000_0111, 8'b1111_1000,
                                 8'b1001_0001, 8'b1111_1111, 8'b0000_0000, 8'b1100_0011,
                                 8'b0000_1111, 8'b0000_1111, 8'b1111_0000};
  logic [63:0]  v_slots [NV] = '{64'h000A_000B_000C_000D, 64'h0001_0002_0003_0004,
                                 64'h0005_0006_0007_0008, 64'h0001_0002_0003_0004,
                                 64'h0011_0022_0033_0044, 64'h00A1_00A2_00A3_00A4,
                                 64'hDEAD_BEEF_CAFE_F00D, 64'h0001_0002_0003_0004,
                                 64'h0051_0052_0053_0054, 64'h0051_0052_0053_0054,
                                 64'h0061_0062_0063_0064};
  logic [127:0] v_exp   [NV] = '{
    {16'h000D, 16'h0000, 16'h000C, 16'h0000, 16'h0000, 16'h000B, 16'h0000, 16'h000A},
    {16'h0000, 16'h0000, 16'h0004, 16'h0003, 16'h0000, 16'h0002, 16'h0001, 16'h0000},
    {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0006, 16'h0005},
    {16'h0000, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000, 16'h0000, 16'h0000},
    {16'h0044, 16'h0000, 16'h0000, 16'h0033, 16'h0000, 16'h0000, 16'h0000, 16'h0011},
    {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1},
    {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000},
    {16'h0004, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0001},
    {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0054, 16'h0053, 16'h0052, 16'h0051},
    {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0052, 16'h0051},
    {16'h0000, 16'h0000, 16'h0064, 16'h0063, 16'h0000, 16'h0000, 16'h0000, 16'h0000}};
  logic         v_err   [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic chk(input string name, input logic [LANES*M*W-1:0] act,
                     input logic [LANES*M*W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic send(input int v);
    exp_t e;
    int   lane;
    lane = int'(v_lane[v]);
    in_vals = {LANES*K*W{1'b1}};
    in_vals[lane*K*W +: K*W] = v_slots[v];
    in_mask = '0;
    in_mask[lane*M +: M] = v_mask[v];
    in_mode = v_mode[v];
    in_valid = 1'b1;
    e.vals = '0;
    e.vals[lane*M*W +: M*W] = v_exp[v];
    e.err = '0;
    e.err[lane] = v_err[v];
    e.id = 8'(v);
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        acc_cyc.push_back(cyc);
        acc_cnt++;
        $display("in  beat v%0d accepted at cycle %0d", v, cyc);
        break;
      end
      if (t > 200) begin
        failures++;
        $display("FAIL accept_timeout v%0d actual=no_ready required=ready", v);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; exp_q.size() != 0; t++) begin
      @(negedge clk);
      if (t > 200) begin
        failures++;
        $display("FAIL drain_timeout actual=%0d_left required=0", exp_q.size());
        exp_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  logic                 stall_prev = 1'b0;
  logic [LANES*M*W-1:0] prev_vals;
  logic [LANES-1:0]     prev_err;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (stall_prev && !rst) begin
      chk("stall_valid", {511'b0, out_valid}, 512'd1);
      chk("stall_vals", out_vals, prev_vals);
      chk("stall_err", {508'b0, out_err}, {508'b0, prev_err});
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h required=no_beat", out_vals);
      end else begin
        e = exp_q.pop_front();
        out_cyc.push_back(cyc);
        $display("out beat v%0d at cycle %0d err=%b", e.id, cyc, out_err);
        chk("out_vals", out_vals, e.vals);
        chk("out_err", {508'b0, out_err}, {508'b0, e.err});
      end
    end
    stall_prev = out_valid && !out_ready;
    prev_vals  = out_vals;
    prev_err   = out_err;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc0;
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {511'b0, in_ready}, 512'd0);
    chk("rst_out_valid", {511'b0, out_valid}, 512'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {511'b0, in_ready}, 512'd1);
    chk("post_rst_out_valid", {511'b0, out_valid}, 512'd0);
    chk("post_rst_out_vals", out_vals, '0);
    chk("post_rst_out_err", {508'b0, out_err}, '0);
    chk("post_rst_sticky", {511'b0, err_sticky}, '0);
    @(posedge clk);
    #1;

    // 4:8 single beat and its 2-cycle latency.
    send(0);
    @(negedge clk);
    chk("lat_cycle1_valid", {511'b0, out_valid}, 512'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", {511'b0, out_valid}, 512'd1);
    drain();
    chk("sticky_clean", {511'b0, err_sticky}, 512'd0);

    // 2:4 legal then over-capacity; sticky then clear.
    send(1);
    send(2);
    drain();
    @(negedge clk);
    chk("sticky_set", {511'b0, err_sticky}, 512'd1);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", {511'b0, err_sticky}, 512'd0);
    @(posedge clk);
    #1;

    // Backpressure: only two beats fit while the output is stalled.
    out_ready = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        send(3);
        send(4);
        send(5);
        send(6);
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_accepted", 512'(acc_cnt - acc0), 512'd2);
        chk("bp_in_ready", {511'b0, in_ready}, 512'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Mixed modes back to back at full rate.
    acc_cyc.delete();
    out_cyc.delete();
    send(8);
    send(9);
    send(10);
    send(7);
    drain();
    for (int i = 1; i < 4; i++) begin
      chk("tput_in", 512'(acc_cyc[i] - acc_cyc[i-1]), 512'd1);
      chk("tput_out", 512'(out_cyc[i] - out_cyc[i-1]), 512'd1);
    end

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(1);
    send(0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", {511'b0, in_ready}, 512'd0);
    chk("midrst_out_valid", {511'b0, out_valid}, 512'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("after_rst_valid", {511'b0, out_valid}, 512'd0);
      chk("after_rst_vals", out_vals, '0);
      chk("after_rst_err", {508'b0, out_err}, '0);
    end
    @(posedge clk);
    #1;
    send(4);
    send(5);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
